// File: rtl/led_frame_sequencer_if.sv
// Driver-side request/colour handshake plus colour RAM read port of the frame sequencer.
// master = sequencer side, slave = led_driver / colour RAM side.
interface led_frame_sequencer_if #(
    parameter int CW = 5
);
    logic [CW-1:0] req_idx;
    logic          req_valid;
    logic [7:0]    green;
    logic [7:0]    red;
    logic [7:0]    blue;
    logic          color_valid;
    logic          force_reset;
    logic          rd_en;
    logic [CW:0]   rd_addr;
    logic [23:0]   rd_data;

    modport master (
        input  req_idx, req_valid, rd_data,
        output green, red, blue, color_valid, force_reset, rd_en, rd_addr
    );

    modport slave (
        output req_idx, req_valid, rd_data,
        input  green, red, blue, color_valid, force_reset, rd_en, rd_addr
    );
endinterface

// File: rtl/led_frame_sequencer.sv
// Paces WS2812B frames, serves in-order colour requests from a double-banked RAM (colour 3 cycles
// after req_valid), swaps banks only at frame start and holds the latch gap. No backpressure.
module led_frame_sequencer #(
    parameter int NUM_LEDS     = 20,
    parameter int FRAME_CYCLES = 1666667,
    parameter int LATCH_CYCLES = 5000
) (
    input  logic                  clk_in,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  commit,
    led_frame_sequencer_if.master bus,
    output logic                  front_bank,
    output logic                  frame_done,
    output logic                  overrun,
    output logic                  proto_err
);
    localparam int CW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int TW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam int LW = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_LEDS - 1);

    typedef enum logic [2:0] {IDLE, ACTIVE, READ, RESP, LATCH} state_t;

    state_t        state;
    logic [TW-1:0] tick_cnt;
    logic          tick_pending;
    logic          commit_pending;
    logic [CW-1:0] expected;
    logic [LW-1:0] latch_cnt;
    logic          tick_wrap;

    assign tick_wrap = (tick_cnt == TW'(FRAME_CYCLES - 1));

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            tick_cnt        <= '0;
            tick_pending    <= 1'b0;
            commit_pending  <= 1'b0;
            expected        <= '0;
            latch_cnt       <= '0;
            front_bank      <= 1'b0;
            frame_done      <= 1'b0;
            overrun         <= 1'b0;
            proto_err       <= 1'b0;
            bus.green       <= '0;
            bus.red         <= '0;
            bus.blue        <= '0;
            bus.color_valid <= 1'b0;
            bus.force_reset <= 1'b0;
            bus.rd_en       <= 1'b0;
            bus.rd_addr     <= '0;
        end else begin
            bus.color_valid <= 1'b0;
            bus.force_reset <= 1'b0;
            frame_done      <= 1'b0;

            tick_cnt <= tick_wrap ? '0 : tick_cnt + TW'(1);
            if (tick_wrap && (tick_pending || state != IDLE))
                overrun <= 1'b1;
            if (commit)
                commit_pending <= 1'b1;

            case (state)
                IDLE: begin
                    if (enable && tick_pending) begin
                        tick_pending <= 1'b0;
                        if (commit_pending) begin
                            front_bank     <= ~front_bank;
                            // a commit landing on the swap cycle belongs to the next frame
                            commit_pending <= commit;
                        end
                        bus.force_reset <= 1'b1;
                        expected        <= '0;
                        state           <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (bus.req_valid) begin
                        if (bus.req_idx == expected) begin
                            bus.rd_en   <= 1'b1;
                            bus.rd_addr <= {front_bank, bus.req_idx};
                            state       <= READ;
                        end else begin
                            proto_err       <= 1'b1;
                            bus.force_reset <= 1'b1;
                            latch_cnt       <= '0;
                            state           <= LATCH;
                        end
                    end
                end
                READ: begin
                    bus.rd_en <= 1'b0;
                    if (bus.req_valid)
                        proto_err <= 1'b1;
                    state <= RESP;
                end
                RESP: begin
                    if (bus.req_valid)
                        proto_err <= 1'b1;
                    {bus.green, bus.red, bus.blue} <= bus.rd_data;
                    bus.color_valid <= 1'b1;
                    expected        <= expected + CW'(1);
                    if (expected == LAST_IDX) begin
                        latch_cnt <= '0;
                        state     <= LATCH;
                    end else begin
                        state <= ACTIVE;
                    end
                end
                LATCH: begin
                    if (latch_cnt == LW'(LATCH_CYCLES - 1)) begin
                        frame_done <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        latch_cnt <= latch_cnt + LW'(1);
                    end
                end
                default: state <= IDLE;
            endcase

            // a wrap always leaves a tick pending, even on the cycle a frame consumes one
            if (tick_wrap)
                tick_pending <= 1'b1;
        end
    end
endmodule

// File: tb/tb_led_frame_sequencer.sv
// Randomised bench for led_frame_sequencer: frame starts are predicted from tick arithmetic,
// colours from a bank/commit model over a random colour RAM.
module tb_led_frame_sequencer;
    localparam int N  = 4;
    localparam int F  = 100;
    localparam int L  = 30;
    localparam int CW = 2;

    logic clk_in = 1'b0;
    logic rst_n  = 1'b0;
    logic enable = 1'b0;
    logic commit = 1'b0;
    logic front_bank, frame_done, overrun, proto_err;

    led_frame_sequencer_if #(.CW(CW)) bus ();

    led_frame_sequencer #(
        .NUM_LEDS    (N),
        .FRAME_CYCLES(F),
        .LATCH_CYCLES(L)
    ) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .enable    (enable),
        .commit    (commit),
        .bus       (bus.master),
        .front_bank(front_bank),
        .frame_done(frame_done),
        .overrun   (overrun),
        .proto_err (proto_err)
    );

    always #5 clk_in = ~clk_in;

    logic [23:0] mem [0:2**(CW+1)-1];
    always @(posedge clk_in)
        if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];

    // edges since reset release; the DUT tick counter equals cyc % F
    int cyc;
    always @(posedge clk_in or negedge rst_n)
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    bit bank, pending, exp_proto;

    task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [47:0] outs();
        return 48'({front_bank, frame_done, overrun, proto_err, bus.color_valid, bus.force_reset,
                    bus.rd_en, bus.rd_addr, bus.green, bus.red, bus.blue});
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        commit = 1'b0;
        bus.req_valid = 1'b0;
        repeat (3) @(negedge clk_in);
        check("reset_outputs", outs(), 48'(0));
        rst_n = 1'b1;
        bank = 1'b0;
        pending = 1'b0;
        exp_proto = 1'b0;
    endtask

    task automatic wait_cyc(input int target, input bit chatter);
        int guard = 0;
        while (cyc < target && guard < 10 * F) begin
            if (chatter) begin
                bus.req_valid = 1'($urandom_range(0, 1));
                bus.req_idx   = CW'($urandom_range(0, N - 1));
            end
            @(negedge clk_in);
            guard++;
        end
        bus.req_valid = 1'b0;
        check("wait_cyc", 48'(cyc), 48'(target));
    endtask

    task automatic frame_start(input int m, input bit commit_start, input bit chatter);
        if (commit_start) begin
            wait_cyc(m * F, chatter);
            commit = 1'b1;
            @(negedge clk_in);
            commit = 1'b0;
        end
        wait_cyc(m * F + 1, chatter && !commit_start);
        bank = bank ^ pending;
        pending = commit_start;
        check("force_reset_start", 48'(bus.force_reset), 48'(1));
        check("front_bank", 48'(front_bank), 48'(bank));
        check("overrun_clear", 48'(overrun), 48'(0));
        check("proto_err_start", 48'(proto_err), 48'(exp_proto));
    endtask

    task automatic serve(input int i, input bit overlap);
        logic [CW:0] addr;
        addr = {bank, CW'(i)};
        bus.req_valid = 1'b1;
        bus.req_idx   = CW'(i);
        @(negedge clk_in);
        bus.req_valid = overlap;
        bus.req_idx   = CW'(i + 1);
        check("rd_en", 48'(bus.rd_en), 48'(1));
        check("rd_addr", 48'(bus.rd_addr), 48'(addr));
        @(negedge clk_in);
        bus.req_valid = 1'b0;
        check("cv_early", 48'(bus.color_valid), 48'(0));
        if (overlap) check("proto_overlap", 48'(proto_err), 48'(1));
        @(negedge clk_in);
        check("color_valid", 48'(bus.color_valid), 48'(1));
        check("color", 48'({bus.green, bus.red, bus.blue}), 48'(mem[addr]));
        @(negedge clk_in);
        check("cv_pulse", 48'(bus.color_valid), 48'(0));
        check("color_hold", 48'({bus.green, bus.red, bus.blue}), 48'(mem[addr]));
    endtask

    task automatic latch_gap(input int exp_gap, input string tag);
        int got = -1;
        int cv = 0;
        for (int k = 1; k <= exp_gap + 5; k++) begin
            @(negedge clk_in);
            if (bus.color_valid) cv++;
            if (frame_done) begin
                got = k;
                break;
            end
        end
        check(tag, 48'(got), 48'(exp_gap));
        check("no_color_in_latch", 48'(cv), 48'(0));
        @(negedge clk_in);
        check("frame_done_pulse", 48'(frame_done), 48'(0));
    endtask

    task automatic run_frame(input int m, input int commit_led, input bit commit_start,
                             input int drop_at, input int overlap_at, input bit chatter);
        frame_start(m, commit_start, chatter);
        @(negedge clk_in);
        check("force_reset_pulse", 48'(bus.force_reset), 48'(0));
        for (int i = 0; i < N; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk_in);
            if (i == commit_led) begin
                commit = 1'b1;
                @(negedge clk_in);
                commit = 1'b0;
                pending = 1'b1;
                check("bank_hold", 48'(front_bank), 48'(bank));
            end
            if (i == drop_at) enable = 1'b0;
            serve(i, i == overlap_at);
            if (i == overlap_at) exp_proto = 1'b1;
        end
        // serve returns one cycle after the last colour pulse
        latch_gap(L - 1, "latch_gap");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        bus.req_valid = 1'b0;
        bus.req_idx   = '0;
        for (int a = 0; a < 2**(CW+1); a++) mem[a] = 24'($urandom);
        @(negedge clk_in);
        do_reset();
        enable = 1'b1;

        run_frame(1, 1, 1'b0, -1, -1, 1'b0);
        run_frame(2, -1, 1'b1, -1, -1, 1'b1);

        // out-of-order request: 0 then 2
        frame_start(3, 1'b0, 1'b1);
        serve(0, 1'b0);
        bus.req_valid = 1'b1;
        bus.req_idx   = CW'(2);
        @(negedge clk_in);
        bus.req_valid = 1'b0;
        check("proto_err_order", 48'(proto_err), 48'(1));
        check("force_reset_err", 48'(bus.force_reset), 48'(1));
        check("rd_en_err", 48'(bus.rd_en), 48'(0));
        latch_gap(L, "latch_gap_err");
        exp_proto = 1'b1;

        run_frame(4, -1, 1'b0, -1, -1, 1'b1);
        run_frame(5, -1, 1'b0, 2, -1, 1'b0);

        // disabled: ticks pile up, second unconsumed tick is an overrun
        cnt = 0;
        while (cyc < 7 * F - 1) begin
            @(negedge clk_in);
            if (bus.force_reset) cnt++;
        end
        check("overrun_before", 48'(overrun), 48'(0));
        @(negedge clk_in);
        check("overrun_idle_ticks", 48'(overrun), 48'(1));
        repeat (10) begin
            @(negedge clk_in);
            if (bus.force_reset) cnt++;
        end
        check("no_frame_disabled", 48'(cnt), 48'(0));

        // reset while a read is in flight
        enable = 1'b1;
        do_reset();
        frame_start(1, 1'b0, 1'b0);
        bus.req_valid = 1'b1;
        bus.req_idx   = '0;
        @(negedge clk_in);
        bus.req_valid = 1'b0;
        check("rd_en_pre_reset", 48'(bus.rd_en), 48'(1));
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", outs(), 48'(0));
        repeat (2) @(negedge clk_in);
        rst_n = 1'b1;
        cnt = 0;
        while (cyc < F) begin
            @(negedge clk_in);
            if (bus.color_valid || bus.force_reset) cnt++;
        end
        check("quiet_after_reset", 48'(cnt), 48'(0));

        run_frame(1, -1, 1'b0, -1, 1, 1'b0);

        // driver goes silent: the next wrap lands mid-frame
        frame_start(2, 1'b0, 1'b0);
        wait_cyc(3 * F - 1, 1'b0);
        check("overrun_pre_wrap", 48'(overrun), 48'(0));
        @(negedge clk_in);
        check("overrun_mid_frame", 48'(overrun), 48'(1));
        repeat (20) @(negedge clk_in);
        check("overrun_sticky", 48'(overrun), 48'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
